alu_seq_divider: RTL and testbench

Multi-cycle unsigned restoring divider, the inverse of the ALU's combinational array multiplier. It sits beside the ALU's functional units and produces quotient and remainder of two 8-bit register operands over WIDTH clock cycles. It uses a START/BUSY/DONE handshake so the control unit can stall the PC while a division is in flight.

---
 rtl/alu_seq_divider.sv | 120 ++++++++++++
 tb/tb_alu_seq_divider.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_divider.sv
// rtl/alu_seq_divider.sv - multi-cycle unsigned restoring divider with START/BUSY/DONE handshake
module alu_seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV_ZERO
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   part_rem;

    logic             accept;
    logic             last_step;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             step_bit;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;

    // The dividend register doubles as the quotient shift register:
    // each step consumes its MSB and shifts the new quotient bit into its LSB.
    always_comb begin
        shifted   = {part_rem, dividend[WIDTH-1]};
        trial     = shifted - {2'b00, divisor};
        step_bit  = ~trial[WIDTH+1];
        rem_next  = step_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
        quo_next  = {dividend[WIDTH-2:0], step_bit};
        last_step = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    accept     = 1'b1;
                    state_next = (DATA2 == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                if (START) begin
                    accept     = 1'b1;
                    state_next = (DATA2 == '0) ? FIN : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count     <= '0;
            dividend  <= '0;
            divisor   <= '0;
            part_rem  <= '0;
            QUOTIENT  <= '0;
            REMAINDER <= '0;
            DIV_ZERO  <= 1'b0;
        end else if (accept) begin
            count    <= '0;
            dividend <= DATA1;
            divisor  <= DATA2;
            part_rem <= '0;
            if (DATA2 == '0) begin
                QUOTIENT  <= '1;
                REMAINDER <= DATA1;
                DIV_ZERO  <= 1'b1;
            end
        end else if (state == RUN) begin
            count    <= count + CW'(1);
            dividend <= quo_next;
            part_rem <= rem_next;
            if (last_step) begin
                QUOTIENT  <= quo_next;
                REMAINDER <= rem_next[WIDTH-1:0];
                DIV_ZERO  <= 1'b0;
            end
        end
    end

    assign BUSY = (state == RUN);
    assign DONE = (state == FIN);

endmodule

// File: tb/tb_alu_seq_divider.sv
// tb/tb_alu_seq_divider.sv - scoreboard bench for alu_seq_divider
module tb_alu_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data1 = '0;
    logic [7:0] data2 = '0;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_zero;

    alu_seq_divider #(.WIDTH(8)) dut (
        .CLK      (clk),
        .RESET    (rst_n),
        .START    (start),
        .DATA1    (data1),
        .DATA2    (data2),
        .QUOTIENT (quotient),
        .REMAINDER(remainder),
        .BUSY     (busy),
        .DONE     (done),
        .DIV_ZERO (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         cyc;
    } exp_t;

    exp_t  sb[$];
    exp_t  mon_e;
    int    cyc = 0;
    int    n_checks = 0;
    int    n_bad = 0;
    logic [16:0] prev_out = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input int done_cyc);
        exp_t e;
        e.q   = (b == 0) ? 8'hFF : a / b;
        e.r   = (b == 0) ? a : a % b;
        e.dz  = (b == 0);
        e.cyc = done_cyc;
        sb.push_back(e);
    endtask

    // Results must only move on a DONE cycle; every DONE must match the oldest pending request.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                check_eq("busy_with_done", busy, 0);
                if (sb.size() == 0) begin
                    check_eq("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("quotient", quotient, mon_e.q);
                    check_eq("remainder", remainder, mon_e.r);
                    check_eq("div_zero", div_zero, mon_e.dz);
                    check_eq("done_cycle", cyc, mon_e.cyc);
                end
            end else if ({quotient, remainder, div_zero} !== prev_out) begin
                check_eq("outputs_stable", {quotient, remainder, div_zero}, prev_out);
            end
        end
        prev_out = {quotient, remainder, div_zero};
    end

    task automatic start_div(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start = 1'b1;
        data1 = a;
        data2 = b;
        @(posedge clk);
        #1;
        push_exp(a, b, cyc + ((b == 0) ? 0 : 8));
        check_eq("busy_after_accept", busy, (b != 0));
        @(negedge clk);
        start = 1'b0;
        data1 = 8'($urandom);
        data2 = 8'($urandom);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check_eq("drain_timeout", sb.size(), 0);
    endtask

    logic [7:0] corner_a [5] = '{8'd200, 8'd255, 8'd5, 8'd255, 8'd0};
    logic [7:0] corner_b [5] = '{8'd7,   8'd1,   8'd9, 8'd128, 8'd3};

    initial begin
        #100000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        #12;
        check_eq("rst_quotient", quotient, 0);
        check_eq("rst_remainder", remainder, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_div_zero", div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            start_div(corner_a[i], corner_b[i]);
            wait_drain();
        end

        start_div(8'd77, 8'd0);
        wait_drain();
        start_div(8'd9, 8'd3);
        wait_drain();

        // START while busy must be ignored
        start_div(8'd100, 8'd10);
        repeat (2) @(negedge clk);
        start = 1'b1;
        data1 = 8'd50;
        data2 = 8'd5;
        @(posedge clk);
        #1;
        check_eq("busy_ignored_start", busy, 1);
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (12) @(negedge clk);

        // asynchronous reset in the middle of a division
        start_div(8'd200, 8'd7);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_quotient", quotient, 0);
        check_eq("midrst_remainder", remainder, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_div_zero", div_zero, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        start_div(8'd12, 8'd5);
        wait_drain();

        // back-to-back with START held high through FIN
        @(negedge clk);
        start = 1'b1;
        data1 = 8'd100;
        data2 = 8'd9;
        @(posedge clk);
        #1;
        k = cyc;
        push_exp(8'd100, 8'd9, k + 8);
        @(negedge clk);
        data1 = 8'd63;
        data2 = 8'd8;
        repeat (9) @(posedge clk);
        #1;
        check_eq("b2b_accept_cycle", cyc, k + 9);
        check_eq("b2b_busy", busy, 1);
        push_exp(8'd63, 8'd8, k + 17);
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
